// File: rtl/pe_sampler_pipe.sv
// PE/RG sampling node: accepts one tree-node packet, draws every child site from the parent's
// substitution-matrix row with LANES parallel LFSR lanes, and returns one registered result packet.
module pe_sampler_pipe #(
   parameter int N_SITES = 16,
   parameter int LANES   = 4,
   parameter int PW      = 10,
   parameter int CW      = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           seed_ID,
   input  logic                 seed_load,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*N_SITES-1:0] in_nucl,
   input  logic [CW-1:0]        in_child1,
   input  logic [CW-1:0]        in_child2,
   input  logic [16*PW-1:0]     in_matrix,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*N_SITES-1:0] out_nucl,
   output logic [CW-1:0]        out_child1,
   output logic [CW-1:0]        out_child2,
   output logic [16*PW-1:0]     out_matrix,
   output logic                 out_leaf,
   output logic                 busy,
   output logic [15:0]          pkt_count
);
   localparam int              CHUNKS     = N_SITES / LANES;
   localparam int              CHW        = $clog2(CHUNKS + 1);
   localparam logic [CHW-1:0]  LAST_CHUNK = CHW'(CHUNKS);
   localparam logic [15:0]     LFSR_BASE  = 16'hACE1;
   localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

   typedef enum logic [1:0] {IDLE, RUN, BYPASS, DONE} state_t;

   state_t         state, state_nx;
   logic [CHW-1:0] chunk;
   logic [15:0]    lfsr [LANES];
   logic [1:0]     samp [LANES];
   logic           drawing;

   // Upper three probabilities {pA,pC,pG} of the row selected by parent nucleotide nt.
   function automatic logic [3*PW-1:0] row_of(input logic [1:0] nt, input logic [16*PW-1:0] m);
      case (nt)
         2'd0:    return m[16*PW-1 -: 3*PW];
         2'd1:    return m[12*PW-1 -: 3*PW];
         2'd2:    return m[8*PW-1  -: 3*PW];
         default: return m[4*PW-1  -: 3*PW];
      endcase
   endfunction

   function automatic logic [1:0] pick(input logic [PW-1:0] u, input logic [3*PW-1:0] p);
      logic [PW+1:0] uu, s1, s2, s3;
      uu = {2'b00, u};
      s1 = {2'b00, p[2*PW +: PW]};
      s2 = s1 + {2'b00, p[PW +: PW]};
      s3 = s2 + {2'b00, p[0 +: PW]};
      if (uu < s1)      return 2'd0;
      else if (uu < s2) return 2'd1;
      else if (uu < s3) return 2'd2;
      else              return 2'd3;
   endfunction

   function automatic logic [15:0] seed_of(input int k, input logic [7:0] id);
      logic [15:0] v;
      v = (LFSR_BASE ^ 16'(k)) ^ {id, ~id};
      return (v == 16'h0000) ? 16'h0001 : v;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               if (in_nucl == '0 || in_matrix == '0) state_nx = BYPASS;
               else                                  state_nx = RUN;
            end
         end
         RUN:    if (chunk == LAST_CHUNK) state_nx = DONE;
         BYPASS: state_nx = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign drawing = (state == RUN) && (chunk != LAST_CHUNK);

   // Sites are resampled in place: each parent site is read once, in the cycle it is overwritten.
   always_comb begin
      for (int j = 0; j < LANES; j++)
         samp[j] = pick(lfsr[j][PW-1:0],
                        row_of(out_nucl[2*(int'(chunk)*LANES + j) +: 2], out_matrix));
   end

   // NOTE: the lane array is reset like any flop; its power-up seeds are part of the contract.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < LANES; k++) lfsr[k] <= LFSR_BASE ^ 16'(k);
      end else if (seed_load && state != RUN) begin
         for (int k = 0; k < LANES; k++) lfsr[k] <= seed_of(k, seed_ID);
      end else if (drawing) begin
         for (int k = 0; k < LANES; k++)
            lfsr[k] <= {1'b0, lfsr[k][15:1]} ^ (lfsr[k][0] ? LFSR_TAPS : 16'h0000);
      end
   end

   // NOTE: sequential state uses <= so every flop sees the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         chunk      <= '0;
         out_nucl   <= '0;
         out_matrix <= '0;
         out_child1 <= '0;
         out_child2 <= '0;
         out_leaf   <= 1'b0;
         pkt_count  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               out_nucl   <= in_nucl;
               out_matrix <= in_matrix;
               out_child1 <= in_child1;
               out_child2 <= in_child2;
               out_leaf   <= (in_child1 == '0) && (in_child2 == '0);
               chunk      <= '0;
            end
            RUN: begin
               if (drawing) begin
                  for (int j = 0; j < LANES; j++)
                     out_nucl[2*(int'(chunk)*LANES + j) +: 2] <= samp[j];
                  chunk <= chunk + CHW'(1);
               end else begin
                  out_matrix <= '0;
               end
            end
            DONE: if (out_ready) pkt_count <= pkt_count + 16'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_pe_sampler_pipe.sv
// Self-checking bench for pe_sampler_pipe: a per-site reference model of the LFSR lanes and the
// threshold rule, checked against the default configuration and a 32-site / 2-lane instance.
module tb_pe_sampler_pipe;
   localparam int PW  = 10;
   localparam int CW  = 3;
   localparam int NS  = 16;
   localparam int LN  = 4;
   localparam int ANS = 32;
   localparam int ALN = 2;

   typedef logic [15:0] lanes_t [32];

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [7:0]         seed_ID;
   logic               seed_load, in_valid, in_ready, out_valid, out_ready, out_leaf, busy;
   logic [2*NS-1:0]    in_nucl, out_nucl;
   logic [CW-1:0]      in_child1, in_child2, out_child1, out_child2;
   logic [16*PW-1:0]   in_matrix, out_matrix;
   logic [15:0]        pkt_count;

   logic               a_seed_load, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_leaf, a_busy;
   logic [2*ANS-1:0]   a_in_nucl, a_out_nucl;
   logic [CW-1:0]      a_in_child1, a_in_child2, a_out_child1, a_out_child2;
   logic [16*PW-1:0]   a_in_matrix, a_out_matrix;
   logic [15:0]        a_pkt_count;

   pe_sampler_pipe #(.N_SITES(NS), .LANES(LN), .PW(PW), .CW(CW)) dut (
      .clk(clk), .reset(reset), .seed_ID(seed_ID), .seed_load(seed_load),
      .in_valid(in_valid), .in_ready(in_ready), .in_nucl(in_nucl),
      .in_child1(in_child1), .in_child2(in_child2), .in_matrix(in_matrix),
      .out_valid(out_valid), .out_ready(out_ready), .out_nucl(out_nucl),
      .out_child1(out_child1), .out_child2(out_child2), .out_matrix(out_matrix),
      .out_leaf(out_leaf), .busy(busy), .pkt_count(pkt_count));

   pe_sampler_pipe #(.N_SITES(ANS), .LANES(ALN), .PW(PW), .CW(CW)) dut_alt (
      .clk(clk), .reset(reset), .seed_ID(seed_ID), .seed_load(a_seed_load),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_nucl(a_in_nucl),
      .in_child1(a_in_child1), .in_child2(a_in_child2), .in_matrix(a_in_matrix),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_nucl(a_out_nucl),
      .out_child1(a_out_child1), .out_child2(a_out_child2), .out_matrix(a_out_matrix),
      .out_leaf(a_out_leaf), .busy(a_busy), .pkt_count(a_pkt_count));

   int     n_cmp = 0;
   int     n_err = 0;
   int     exp_count, a_exp_count;
   lanes_t m_lfsr, a_lfsr;

   // ---------------- reference model ----------------
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic model_reset(output lanes_t st);
      for (int k = 0; k < 32; k++) st[k] = 16'hACE1 ^ 16'(k);
   endtask

   task automatic model_seed(input logic [7:0] s, inout lanes_t st);
      logic [15:0] v;
      for (int k = 0; k < 32; k++) begin
         v = (16'hACE1 ^ 16'(k)) ^ {s, ~s};
         st[k] = (v == 16'h0) ? 16'h0001 : v;
      end
   endtask

   // Site i is drawn by lane i % ln; each lane consumes its draws in increasing site order.
   task automatic model_pkt(input int ns, input int ln, input logic [63:0] nucl,
                            input logic [16*PW-1:0] mat, inout lanes_t st, output logic [63:0] res);
      int p, top, pa, pc, pg, u, lane;
      res = nucl;
      if (nucl == 64'h0 || mat == '0) return;
      for (int i = 0; i < ns; i++) begin
         p    = int'(nucl[2*i +: 2]);
         top  = 16*PW - 1 - 4*PW*p;
         pa   = int'(mat[top -: PW]);
         pc   = int'(mat[top - PW -: PW]);
         pg   = int'(mat[top - 2*PW -: PW]);
         lane = i % ln;
         u    = int'(st[lane]) % (1 << PW);
         st[lane] = lfsr_next(st[lane]);
         if (u < pa)                res[2*i +: 2] = 2'd0;
         else if (u < pa + pc)      res[2*i +: 2] = 2'd1;
         else if (u < pa + pc + pg) res[2*i +: 2] = 2'd2;
         else                       res[2*i +: 2] = 2'd3;
      end
   endtask

   function automatic logic [16*PW-1:0] rand_matrix();
      logic [16*PW-1:0] m;
      for (int e = 0; e < 16; e++) begin
         case ($urandom_range(0, 3))
            0:       m[e*PW +: PW] = '0;
            1:       m[e*PW +: PW] = '1;
            default: m[e*PW +: PW] = PW'($urandom_range(0, (1 << PW) - 1));
         endcase
      end
      if (m == '0) m[0] = 1'b1;
      return m;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      model_reset(m_lfsr);
      model_reset(a_lfsr);
      exp_count   = 0;
      a_exp_count = 0;
   endtask

   task automatic send(input logic [2*NS-1:0] n, input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                       input logic [16*PW-1:0] m);
      in_nucl = n; in_child1 = c1; in_child2 = c2; in_matrix = m; in_valid = 1'b1;
      for (int t = 0; t < 200 && !in_ready; t++) tick();
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin tick(); lat++; end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_count++;
   endtask

   task automatic a_send(input logic [2*ANS-1:0] n, input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                         input logic [16*PW-1:0] m);
      a_in_nucl = n; a_in_child1 = c1; a_in_child2 = c2; a_in_matrix = m; a_in_valid = 1'b1;
      for (int t = 0; t < 200 && !a_in_ready; t++) tick();
      tick();
      a_in_valid = 1'b0;
   endtask

   task automatic a_wait_out(output int lat);
      lat = 0;
      while (!a_out_valid && lat < 200) begin tick(); lat++; end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      #7;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (pkt_count !== 16'h0) begin n_err++; $display("FAIL reset_pkt_count: got %h want 0", pkt_count); end
      n_cmp++; if (out_nucl !== '0 || out_matrix !== '0) begin n_err++; $display("FAIL reset_out_data: nucl %h matrix %h want 0", out_nucl, out_matrix); end
      n_cmp++; if ({out_leaf, out_child1, out_child2} !== '0) begin n_err++; $display("FAIL reset_out_ids: leaf %b c1 %0d c2 %0d want 0", out_leaf, out_child1, out_child2); end
      n_cmp++; if (a_in_ready !== 1'b1 || a_busy !== 1'b0) begin n_err++; $display("FAIL reset_alt: in_ready %b busy %b want 1/0", a_in_ready, a_busy); end
      tick();
      reset = 1'b1;
      tick();
      model_reset(m_lfsr);
      model_reset(a_lfsr);
      exp_count   = 0;
      a_exp_count = 0;
   endtask

   task automatic test_all_t();
      logic [16*PW-1:0] m;
      logic [63:0]      r;
      int               lat;
      m = {4{PW'(0), PW'(0), PW'(0), PW'(1)}};
      model_pkt(NS, LN, 64'h1B1B_1B1B, m, m_lfsr, r);
      send(32'h1B1B_1B1B, 3'd2, 3'd5, m);
      wait_out(lat);
      n_cmp++; if (lat !== NS/LN + 1) begin n_err++; $display("FAIL all_t_latency: got %0d want %0d", lat, NS/LN + 1); end
      n_cmp++; if (out_nucl !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL all_t_nucl: got %h want ffffffff", out_nucl); end
      n_cmp++; if (out_matrix !== '0) begin n_err++; $display("FAIL all_t_matrix: got %h want 0", out_matrix); end
      n_cmp++; if (out_child1 !== 3'd2 || out_child2 !== 3'd5 || out_leaf !== 1'b0) begin n_err++; $display("FAIL all_t_ids: c1 %0d c2 %0d leaf %b want 2 5 0", out_child1, out_child2, out_leaf); end
      accept();
      n_cmp++; if (pkt_count !== 16'(exp_count)) begin n_err++; $display("FAIL all_t_count: got %0d want %0d", pkt_count, exp_count); end
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL all_t_release: out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_bypass();
      logic [16*PW-1:0] m;
      int               lat;
      send(32'h1234_5678, 3'd3, 3'd0, '0);
      wait_out(lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL bypass_latency: got %0d want 1", lat); end
      n_cmp++; if (out_nucl !== 32'h1234_5678 || out_matrix !== '0) begin n_err++; $display("FAIL bypass_echo: nucl %h matrix %h want 12345678/0", out_nucl, out_matrix); end
      n_cmp++; if (out_child1 !== 3'd3 || out_child2 !== 3'd0 || out_leaf !== 1'b0) begin n_err++; $display("FAIL bypass_ids: c1 %0d c2 %0d leaf %b want 3 0 0", out_child1, out_child2, out_leaf); end
      accept();
      m = rand_matrix();
      send('0, 3'd0, 3'd0, m);
      wait_out(lat);
      n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL bypass_leaf_latency: got %0d want 1", lat); end
      n_cmp++; if (out_matrix !== m || out_nucl !== '0) begin n_err++; $display("FAIL bypass_leaf_echo: matrix %h nucl %h want %h/0", out_matrix, out_nucl, m); end
      n_cmp++; if (out_leaf !== 1'b1) begin n_err++; $display("FAIL bypass_leaf: got %b want 1", out_leaf); end
      accept();
   endtask

   task automatic test_backpressure();
      logic [16*PW-1:0] m1, m2;
      logic [31:0]      n1, n2;
      logic [63:0]      r1, r2;
      int               lat;
      n1 = $urandom(); if (n1 == 0) n1 = 1;
      n2 = $urandom(); if (n2 == 0) n2 = 1;
      m1 = rand_matrix();
      m2 = rand_matrix();
      model_pkt(NS, LN, {32'h0, n1}, m1, m_lfsr, r1);
      send(n1, 3'd1, 3'd6, m1);
      wait_out(lat);
      in_nucl = n2; in_child1 = 3'd4; in_child2 = 3'd0; in_matrix = m2; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_nucl !== r1[31:0] || out_matrix !== '0 ||
             out_child1 !== 3'd1 || out_child2 !== 3'd6) begin
            n_err++;
            $display("FAIL hold_cycle%0d: valid %b in_ready %b nucl %h c1 %0d c2 %0d want 1 0 %h 1 6",
                     c, out_valid, in_ready, out_nucl, out_child1, out_child2, r1[31:0]);
         end
         tick();
      end
      accept();
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release: out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
      n_cmp++; if (pkt_count !== 16'(exp_count)) begin n_err++; $display("FAIL hold_count: got %0d want %0d", pkt_count, exp_count); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL hold_next_accept: busy %b in_ready %b want 1/0", busy, in_ready); end
      model_pkt(NS, LN, {32'h0, n2}, m2, m_lfsr, r2);
      wait_out(lat);
      n_cmp++; if (lat !== NS/LN + 1) begin n_err++; $display("FAIL hold_next_latency: got %0d want %0d", lat, NS/LN + 1); end
      n_cmp++; if (out_nucl !== r2[31:0]) begin n_err++; $display("FAIL hold_next_nucl: got %h want %h", out_nucl, r2[31:0]); end
      accept();
   endtask

   task automatic test_reset_mid_run();
      logic [16*PW-1:0] m;
      logic [31:0]      n;
      logic [63:0]      r;
      int               lat;
      n = $urandom(); if (n == 0) n = 1;
      m = rand_matrix();
      do_reset();
      model_pkt(NS, LN, {32'h0, n}, m, m_lfsr, r);
      send(n, 3'd7, 3'd7, m);
      wait_out(lat);
      n_cmp++; if (out_nucl !== r[31:0]) begin n_err++; $display("FAIL midrun_first: got %h want %h", out_nucl, r[31:0]); end
      accept();
      do_reset();
      send(n, 3'd7, 3'd7, m);
      tick();
      tick();
      reset = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrun_abort_ctrl: in_ready %b out_valid %b busy %b want 1 0 0", in_ready, out_valid, busy); end
      n_cmp++; if (out_nucl !== '0 || out_matrix !== '0 || pkt_count !== 16'h0 || out_leaf !== 1'b0) begin n_err++; $display("FAIL midrun_abort_data: nucl %h matrix %h count %0d leaf %b want all 0", out_nucl, out_matrix, pkt_count, out_leaf); end
      tick();
      reset = 1'b1;
      tick();
      model_reset(m_lfsr);
      model_reset(a_lfsr);
      exp_count   = 0;
      a_exp_count = 0;
      model_pkt(NS, LN, {32'h0, n}, m, m_lfsr, r);
      send(n, 3'd7, 3'd7, m);
      wait_out(lat);
      n_cmp++; if (out_nucl !== r[31:0]) begin n_err++; $display("FAIL midrun_replay: got %h want %h", out_nucl, r[31:0]); end
      accept();
   endtask

   task automatic test_random_seeded();
      logic [16*PW-1:0] m;
      logic [31:0]      n;
      logic [63:0]      r;
      logic [CW-1:0]    c1, c2;
      logic [7:0]       s;
      int               lat, extra, exp_lat;
      logic             byp;
      seed_ID = 8'h5A; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      model_seed(8'h5A, m_lfsr);
      for (int p = 0; p < 100; p++) begin
         n  = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom();
         m  = ($urandom_range(0, 15) == 0) ? '0 : rand_matrix();
         c1 = ($urandom_range(0, 3) == 0) ? 3'd0 : CW'($urandom_range(0, 7));
         c2 = ($urandom_range(0, 3) == 0) ? 3'd0 : CW'($urandom_range(0, 7));
         byp = (n == 0) || (m == '0);
         model_pkt(NS, LN, {32'h0, n}, m, m_lfsr, r);
         send(n, c1, c2, m);
         extra = 0;
         if (p % 10 == 3) begin
            // A reseed lands during BYPASS but must be ignored during RUN.
            s = 8'($urandom());
            seed_ID = s; seed_load = 1'b1;
            tick();
            seed_load = 1'b0;
            extra = 1;
            if (byp) model_seed(s, m_lfsr);
         end
         wait_out(lat);
         lat     = lat + extra;
         exp_lat = byp ? 1 : NS/LN + 1;
         n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", p, lat, exp_lat); end
         n_cmp++; if (out_nucl !== r[31:0]) begin n_err++; $display("FAIL rnd%0d_nucl: got %h want %h", p, out_nucl, r[31:0]); end
         n_cmp++; if (out_matrix !== (byp ? m : '0)) begin n_err++; $display("FAIL rnd%0d_matrix: got %h want %h", p, out_matrix, byp ? m : '0); end
         n_cmp++; if (out_child1 !== c1 || out_child2 !== c2 || out_leaf !== (c1 == 0 && c2 == 0)) begin n_err++; $display("FAIL rnd%0d_ids: c1 %0d c2 %0d leaf %b want %0d %0d %b", p, out_child1, out_child2, out_leaf, c1, c2, (c1 == 0 && c2 == 0)); end
         for (int d = $urandom_range(0, 2); d > 0; d--) tick();
         accept();
      end
      n_cmp++; if (pkt_count !== 16'(exp_count)) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", pkt_count, exp_count); end
   endtask

   task automatic test_alt_config();
      logic [16*PW-1:0] m;
      logic [63:0]      n, r;
      int               lat;
      seed_ID = 8'h5A; a_seed_load = 1'b1;
      tick();
      a_seed_load = 1'b0;
      model_seed(8'h5A, a_lfsr);
      for (int p = 0; p < 20; p++) begin
         n = {$urandom(), $urandom()}; if (n == 0) n = 1;
         m = rand_matrix();
         model_pkt(ANS, ALN, n, m, a_lfsr, r);
         a_send(n, 3'd1, 3'd2, m);
         a_wait_out(lat);
         n_cmp++; if (lat !== ANS/ALN + 1) begin n_err++; $display("FAIL alt%0d_latency: got %0d want %0d", p, lat, ANS/ALN + 1); end
         n_cmp++; if (a_out_nucl !== r || a_out_matrix !== '0) begin n_err++; $display("FAIL alt%0d_nucl: got %h matrix %h want %h/0", p, a_out_nucl, a_out_matrix, r); end
         a_out_ready = 1'b1;
         tick();
         a_out_ready = 1'b0;
         a_exp_count++;
      end
      n_cmp++; if (a_pkt_count !== 16'(a_exp_count)) begin n_err++; $display("FAIL alt_count: got %0d want %0d", a_pkt_count, a_exp_count); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0; seed_ID = '0; seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_nucl = '0; in_child1 = '0; in_child2 = '0; in_matrix = '0;
      a_seed_load = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      a_in_nucl = '0; a_in_child1 = '0; a_in_child2 = '0; a_in_matrix = '0;
      exp_count = 0; a_exp_count = 0;
      model_reset(m_lfsr);
      model_reset(a_lfsr);
      test_reset();
      test_all_t();
      test_bypass();
      test_backpressure();
      test_reset_mid_run();
      test_random_seeded();
      test_alt_config();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
